// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the state/key registers and the round counter,
// while the round function and key expansion live outside as combinational logic.
//
// state | meaning
// IDLE  | ready for a new plaintext/key pair
// ROUND | round r (1..10) being applied by the external round unit
// DONE  | ciphertext held on out_data until the consumer takes it
module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic [0:127] in_key,
    output logic [0:127] rnd_state_o,
    output logic [0:127] rnd_prev_key_o,
    output logic [3:0]   rnd_num_o,
    output logic         rnd_last_o,
    input  logic [0:127] rnd_key_i,
    input  logic [0:127] rnd_state_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] LAST_RND = 4'd10;

    logic [1:0]   r_fsm;
    logic [3:0]   r_rnd;
    logic [0:127] r_state;
    logic [0:127] r_key;

    logic w_idle;
    logic w_round;
    logic w_done;

    assign w_idle  = (r_fsm == IDLE);
    assign w_round = (r_fsm == ROUND);
    assign w_done  = (r_fsm == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_rnd   <= 4'd0;
            r_state <= '0;
            r_key   <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data ^ in_key;
                        r_key   <= in_key;
                        r_rnd   <= 4'd1;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= rnd_state_i;
                    r_key   <= rnd_key_i;
                    if (r_rnd < LAST_RND) begin
                        r_rnd <= r_rnd + 4'd1;
                    end else begin
                        r_rnd <= 4'd0;
                        r_fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm <= IDLE;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                    r_rnd <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready       = w_idle;
    assign busy           = w_round | w_done;
    assign rnd_state_o    = r_state;
    assign rnd_prev_key_o = r_key;
    assign rnd_num_o      = w_round ? r_rnd : 4'd0;
    assign rnd_last_o     = w_round && (r_rnd == LAST_RND);
    assign out_valid      = w_done;
    // Masked so a stale ciphertext never leaks while out_valid is low.
    assign out_data       = w_done ? r_state : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: supplies a FIPS-197 round unit and key expansion step,
// and scores each ciphertext against an independent full AES-128 encryption.
module tb_aes_round_ctrl;

    typedef logic [0:127] blk_t;

    localparam blk_t V1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam blk_t V1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam blk_t V1_R1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam blk_t V1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    blk_t       in_data;
    blk_t       in_key;
    blk_t       rnd_state_o;
    blk_t       rnd_prev_key_o;
    logic [3:0] rnd_num_o;
    logic       rnd_last_o;
    blk_t       rnd_key_i;
    blk_t       rnd_state_i;
    logic       out_valid;
    logic       out_ready;
    blk_t       out_data;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    blk_t exp_q[$];

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_key         (in_key),
        .rnd_state_o    (rnd_state_o),
        .rnd_prev_key_o (rnd_prev_key_o),
        .rnd_num_o      (rnd_num_o),
        .rnd_last_o     (rnd_last_o),
        .rnd_key_i      (rnd_key_i),
        .rnd_state_i    (rnd_state_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy)
    );

    // ---------------- FIPS-197 model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] res  = 8'h01;
        logic [7:0] base = a;
        logic [7:0] e    = 8'd254;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) res = gmul(res, base);
            base = gmul(base, base);
        end
        b = res;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic blk_t next_key(input blk_t k, input logic [3:0] r);
        blk_t       n;
        logic [7:0] t [4];
        t[0] = sb(k[104 +: 8]) ^ rcon(r);
        t[1] = sb(k[112 +: 8]);
        t[2] = sb(k[120 +: 8]);
        t[3] = sb(k[96 +: 8]);
        for (int i = 0; i < 4; i++) n[8*i +: 8] = k[8*i +: 8] ^ t[i];
        for (int i = 4; i < 16; i++) n[8*i +: 8] = k[8*i +: 8] ^ n[8*(i-4) +: 8];
        return n;
    endfunction

    function automatic blk_t aes_round(input blk_t s, input blk_t k, input logic last);
        logic [7:0] t [16];
        logic [7:0] u [16];
        logic [7:0] a0, a1, a2, a3;
        blk_t       o;
        for (int i = 0; i < 16; i++) t[i] = sb(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) u[r + 4*c] = t[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
            if (last) begin
                o[32*c +: 32] = {a0, a1, a2, a3};
            end else begin
                o[32*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                o[32*c + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return o ^ k;
    endfunction

    function automatic blk_t aes_encrypt(input blk_t pt, input blk_t key);
        blk_t s = pt ^ key;
        blk_t k = key;
        for (int r = 1; r <= 10; r++) begin
            k = next_key(k, 4'(r));
            s = aes_round(s, k, r == 10);
        end
        return s;
    endfunction

    function automatic blk_t rnd_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // external round unit and key expansion
    assign rnd_key_i   = next_key(rnd_prev_key_o, rnd_num_o);
    assign rnd_state_i = aes_round(rnd_state_o, rnd_key_i, rnd_last_o);

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_valid(inout int cnt);
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic accept(input blk_t pt, input blk_t key);
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        exp_q.push_back(aes_encrypt(pt, key));
        step();
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if ({rnd_num_o, rnd_last_o} !== 5'd0) begin n_fail++; $display("FAIL reset_rnd got %0d/%b want 0/0", rnd_num_o, rnd_last_o); end
        n_checks++; if (rnd_state_o !== '0 || rnd_prev_key_o !== '0) begin n_fail++; $display("FAIL reset_regs got %h %h want 0", rnd_state_o, rnd_prev_key_o); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_known_vector();
        blk_t e;
        out_ready = 1'b0;
        accept(V1_PT, V1_KEY);
        n_checks++; if (rnd_state_o !== V1_R1) begin n_fail++; $display("FAIL v1_state_r1 got %h want %h", rnd_state_o, V1_R1); end
        n_checks++; if (rnd_prev_key_o !== V1_KEY) begin n_fail++; $display("FAIL v1_key_r1 got %h want %h", rnd_prev_key_o, V1_KEY); end
        n_checks++; if ({in_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL v1_ready_busy got %b want 01", {in_ready, busy}); end
        for (int r = 1; r <= 10; r++) begin
            n_checks++;
            if ({rnd_num_o, rnd_last_o, out_valid} !== {4'(r), (r == 10), 1'b0}) begin
                n_fail++;
                $display("FAIL v3_round_seq cycle %0d got num=%0d last=%b ov=%b want num=%0d last=%b ov=0",
                         r, rnd_num_o, rnd_last_o, out_valid, r, (r == 10));
            end
            step();
        end
        e = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL v1_latency out_valid got %b want 1 in cycle 11", out_valid); end
        n_checks++; if (out_data !== V1_CT) begin n_fail++; $display("FAIL v1_ciphertext got %h want %h", out_data, V1_CT); end
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL v1_model got %h want %h", out_data, e); end
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            step();
            n_checks++;
            if ({out_valid, in_ready, busy} !== 3'b101 || out_data !== V1_CT) begin
                n_fail++;
                $display("FAIL v2_hold cycle %0d got ov/ir/busy=%b data=%h want 101 data=%h",
                         i, {out_valid, in_ready, busy}, out_data, V1_CT);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL v2_release got ov/ir/busy=%b want 010", {out_valid, in_ready, busy}); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL v2_data_cleared got %h want 0", out_data); end
    endtask

    task automatic test_async_reset();
        int   cnt;
        blk_t e;
        accept(rnd_blk(), rnd_blk());
        cnt = 0;
        while (rnd_num_o !== 4'd5 && cnt < 20) begin step(); cnt++; end
        n_checks++; if (rnd_num_o !== 4'd5) begin n_fail++; $display("FAIL v4_reach_r5 got %0d want 5", rnd_num_o); end
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if ({in_ready, out_valid, busy, rnd_num_o} !== 7'b1000000 || rnd_state_o !== '0 || rnd_prev_key_o !== '0) begin
            n_fail++;
            $display("FAIL v4_async_reset got ir/ov/busy=%b num=%0d state=%h key=%h want 100 0 0 0",
                     {in_ready, out_valid, busy}, rnd_num_o, rnd_state_o, rnd_prev_key_o);
        end
        step();
        n_checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin n_fail++; $display("FAIL v4_reset_hold got %b want 100", {in_ready, out_valid, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        accept(rnd_blk(), rnd_blk());
        cnt = 1;
        run_until_valid(cnt);
        e = exp_q.pop_front();
        n_checks++; if (cnt !== 11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL v4_latency got %0d want 11", cnt); end
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL v4_ciphertext got %h want %h", out_data, e); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   cnt;
        blk_t e;
        blk_t pb, kb;
        pb = rnd_blk();
        kb = rnd_blk();
        out_ready = 1'b1;
        in_data   = rnd_blk();
        in_key    = rnd_blk();
        in_valid  = 1'b1;
        exp_q.push_back(aes_encrypt(in_data, in_key));
        step();
        in_data = pb;
        in_key  = kb;
        exp_q.push_back(aes_encrypt(pb, kb));
        cnt = 1;
        run_until_valid(cnt);
        e = exp_q.pop_front();
        n_checks++; if (cnt !== 11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL v5_latency_a got %0d want 11", cnt); end
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL v5_ciphertext_a got %h want %h", out_data, e); end
        step();
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL v5_handshake got ov/ir=%b want 01", {out_valid, in_ready}); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, busy, rnd_num_o} !== 6'b010001 || rnd_state_o !== (pb ^ kb)) begin
            n_fail++;
            $display("FAIL v5_second_accept got ir/busy=%b num=%0d state=%h want 01 1 %h",
                     {in_ready, busy}, rnd_num_o, rnd_state_o, pb ^ kb);
        end
        cnt = 1;
        run_until_valid(cnt);
        e = exp_q.pop_front();
        n_checks++; if (cnt !== 11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL v5_latency_b got %0d want 11", cnt); end
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL v5_ciphertext_b got %h want %h", out_data, e); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_ignore_inputs();
        int   cnt;
        blk_t e;
        accept(rnd_blk(), rnd_blk());
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd_blk();
            in_key   = rnd_blk();
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL v6_in_ready cycle %0d got %b want 0", cnt, in_ready); end
            step();
            cnt++;
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (cnt !== 11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL v6_latency got %0d want 11", cnt); end
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL v6_ciphertext got %h want %h", out_data, e); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random_blocks();
        int   cnt;
        int   dly;
        blk_t e;
        for (int b = 0; b < 3; b++) begin
            accept(rnd_blk(), rnd_blk());
            cnt = 1;
            run_until_valid(cnt);
            dly = $urandom_range(0, 5);
            for (int i = 0; i < dly; i++) step();
            e = exp_q.pop_front();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid blk %0d got %b want 1", b, out_valid); end
            n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL rand_ciphertext blk %0d got %h want %h", b, out_data, e); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_async_reset();
        test_back_to_back();
        test_ignore_inputs();
        test_random_blocks();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
